// File: rtl/fetch_stage_if.sv
// fetch_stage_if -- instruction-memory port between the fetch stage and imem.
//   imemREN   fetch side -> memory : read request
//   imemaddr  fetch side -> memory : fetch address (current PC)
//   ihit      memory -> fetch side : imemload is valid this cycle
//   imemload  memory -> fetch side : instruction word
interface fetch_stage_if;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;

   modport master (output imemREN, output imemaddr, input ihit, input imemload);
   modport slave  (input imemREN, input imemaddr, output ihit, output imemload);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch: PC register, next-PC select, imem request,
// one-entry hold buffer and the IF/ID latch feeding decode.
//
// Ports:
//   CLK, nRST                  clock (rising edge), async active-low reset
//   PC_EN, IF_EN, IF_FLUSH     hazard-unit PC / latch controls
//   iREN, pr_halt              hazard-unit fetch enable and halt
//   PCSrc/branch_target        taken branch from EX (highest priority)
//   ID_JR/jr_target            JR from EX
//   cu_Jump/jump_target        J/JAL from decode
//   imem                       instruction-memory port (fetch_stage_if.master)
//   IF_instr/IF_pc/IF_npc      IF/ID latch contents
//   IF_valid                   latch holds a real instruction
//   IF_rs/IF_rt                register fields of IF_instr for load-use check
//   halted                     fetch permanently stopped until reset
//
// Optional: define FETCH_PERF_EN to add fetch_count / stall_count outputs.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_RUN   | normal fetch, imem request follows iREN
// S_HOLD  | fetched word parked in hold buffer while decode is stalled
// S_HALTED| fetch stopped, PC frozen, sticky until reset
module fetch_stage #(
   parameter logic [31:0] PC_INIT  = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic                 CLK,
   input  logic                 nRST,
   input  logic                 PC_EN,
   input  logic                 IF_EN,
   input  logic                 IF_FLUSH,
   input  logic                 iREN,
   input  logic                 pr_halt,
   input  logic                 PCSrc,
   input  logic [31:0]          branch_target,
   input  logic                 ID_JR,
   input  logic [31:0]          jr_target,
   input  logic                 cu_Jump,
   input  logic [31:0]          jump_target,
   fetch_stage_if.master        imem,
   output logic [31:0]          IF_instr,
   output logic [31:0]          IF_pc,
   output logic [31:0]          IF_npc,
   output logic                 IF_valid,
   output logic [4:0]           IF_rs,
   output logic [4:0]           IF_rt,
   output logic                 halted
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]          fetch_count,
   output logic [31:0]          stall_count
`endif
);

   typedef enum logic [1:0] {S_RUN, S_HOLD, S_HALTED} state_t;

   state_t      state_q;
   logic        halted_q;
   logic [31:0] pc_q, pc_d, pc_plus4;
   logic [31:0] hb_instr_q, hb_pc_q, hb_npc_q;
   logic [31:0] if_instr_q, if_pc_q, if_npc_q;
   logic        if_valid_q;
   logic        redirect;
   logic        hold_capture;
   logic        latch_load;

   assign pc_plus4 = pc_q + 32'd4;
   assign redirect = PCSrc | ID_JR;

   always_comb begin
      pc_d = pc_plus4;
      if (PCSrc)        pc_d = branch_target;
      else if (ID_JR)   pc_d = jr_target;
      else if (cu_Jump) pc_d = jump_target;
   end

   // A word returned while decode is stalled is parked; a word returned in the
   // same cycle as a redirect is stale and simply dropped.
   assign hold_capture = (state_q == S_RUN) && imem.ihit && !IF_EN && !IF_FLUSH && !redirect;

   assign latch_load = !IF_FLUSH && (state_q != S_HALTED) && IF_EN &&
                       ((state_q == S_HOLD) || imem.ihit);

   // Request is forced low during reset so memory never sees a stray fetch.
   assign imem.imemREN  = iREN && (state_q == S_RUN) && nRST;
   assign imem.imemaddr = pc_q;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q    <= S_RUN;
         halted_q   <= 1'b0;
         hb_instr_q <= NOP_WORD;
         hb_pc_q    <= 32'h0;
         hb_npc_q   <= 32'h0;
      end else begin
         case (state_q)
            S_RUN: begin
               if (hold_capture) begin
                  state_q    <= S_HOLD;
                  hb_instr_q <= imem.imemload;
                  hb_pc_q    <= pc_q;
                  hb_npc_q   <= pc_plus4;
               end
            end
            S_HOLD: begin
               if (IF_EN || IF_FLUSH || redirect) state_q <= S_RUN;
            end
            default: state_q <= S_HALTED;
         endcase
         if (pr_halt) begin
            state_q  <= S_HALTED;
            halted_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         pc_q <= PC_INIT;
      end else if (PC_EN && (state_q != S_HALTED)) begin
         pc_q <= pc_d;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         if_instr_q <= NOP_WORD;
         if_pc_q    <= 32'h0;
         if_npc_q   <= 32'h0;
         if_valid_q <= 1'b0;
      end else if (IF_FLUSH) begin
         if_instr_q <= NOP_WORD;
         if_valid_q <= 1'b0;
      end else if (IF_EN && (state_q != S_HALTED)) begin
         if (state_q == S_HOLD) begin
            if_instr_q <= hb_instr_q;
            if_pc_q    <= hb_pc_q;
            if_npc_q   <= hb_npc_q;
            if_valid_q <= 1'b1;
         end else if (imem.ihit) begin
            if_instr_q <= imem.imemload;
            if_pc_q    <= pc_q;
            if_npc_q   <= pc_plus4;
            if_valid_q <= 1'b1;
         end else begin
            if_instr_q <= NOP_WORD;
            if_valid_q <= 1'b0;
         end
      end
   end

   assign IF_instr = if_instr_q;
   assign IF_pc    = if_pc_q;
   assign IF_npc   = if_npc_q;
   assign IF_valid = if_valid_q;
   assign IF_rs    = if_instr_q[25:21];
   assign IF_rt    = if_instr_q[20:16];
   assign halted   = halted_q;

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt_q, stall_cnt_q;
   logic        stall_evt;

   assign stall_evt = (state_q == S_RUN) && imem.imemREN && !imem.ihit;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         fetch_cnt_q <= 32'h0;
         stall_cnt_q <= 32'h0;
      end else if (state_q != S_HALTED) begin
         if (latch_load && (fetch_cnt_q != 32'hFFFF_FFFF)) fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (stall_evt && (stall_cnt_q != 32'hFFFF_FFFF))  stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign fetch_count = fetch_cnt_q;
   assign stall_count = stall_cnt_q;
`else
   logic unused_latch_load;
   assign unused_latch_load = latch_load;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
   localparam logic [31:0] PC_INIT  = 32'h0000_0000;
   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   localparam int SEL_ADDR = 0, SEL_REN = 1, SEL_INSTR = 2, SEL_PC = 3, SEL_NPC = 4,
                  SEL_VALID = 5, SEL_RS = 6, SEL_RT = 7, SEL_HALT = 8, SEL_FCNT = 9,
                  SEL_SCNT = 10;

   localparam logic [31:0] W0 = 32'h2001_0005, W1 = 32'h2002_0007, W2 = 32'h8D2A_0004,
                           W3 = 32'h0128_4020, W4 = 32'hDEAD_BEEF, W5 = 32'hAC0B_0008,
                           W6 = 32'h1234_5678, W7 = 32'hFFFF_0000, WA = 32'h3C01_1111,
                           WB = 32'h3C02_2222;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        PC_EN, IF_EN, IF_FLUSH, iREN, pr_halt;
   logic        PCSrc, ID_JR, cu_Jump;
   logic [31:0] branch_target, jr_target, jump_target;
   logic [31:0] IF_instr, IF_pc, IF_npc;
   logic        IF_valid, halted;
   logic [4:0]  IF_rs, IF_rt;
`ifdef FETCH_PERF_EN
   logic [31:0] fetch_count, stall_count;
`endif

   fetch_stage_if imem_if ();

   fetch_stage #(.PC_INIT(PC_INIT), .NOP_WORD(NOP_WORD)) dut (
      .CLK(CLK), .nRST(nRST), .PC_EN(PC_EN), .IF_EN(IF_EN), .IF_FLUSH(IF_FLUSH),
      .iREN(iREN), .pr_halt(pr_halt), .PCSrc(PCSrc), .branch_target(branch_target),
      .ID_JR(ID_JR), .jr_target(jr_target), .cu_Jump(cu_Jump), .jump_target(jump_target),
      .imem(imem_if), .IF_instr(IF_instr), .IF_pc(IF_pc), .IF_npc(IF_npc),
      .IF_valid(IF_valid), .IF_rs(IF_rs), .IF_rt(IF_rt), .halted(halted)
`ifdef FETCH_PERF_EN
      , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int          cyc;
      int          sel;
      logic [31:0] exp;
   } chk_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } load_t;

   chk_t  chk_q[$];
   load_t load_q[$];
   int    cyc = 0;
   int    checks = 0;
   int    errors = 0;

   always @(posedge CLK) cyc++;

   function automatic string sel_name(input int sel);
      case (sel)
         SEL_ADDR:  return "imemaddr";
         SEL_REN:   return "imemREN";
         SEL_INSTR: return "IF_instr";
         SEL_PC:    return "IF_pc";
         SEL_NPC:   return "IF_npc";
         SEL_VALID: return "IF_valid";
         SEL_RS:    return "IF_rs";
         SEL_RT:    return "IF_rt";
         SEL_HALT:  return "halted";
         SEL_FCNT:  return "fetch_count";
         default:   return "stall_count";
      endcase
   endfunction

   function automatic logic [31:0] get_sig(input int sel);
      case (sel)
         SEL_ADDR:  return imem_if.imemaddr;
         SEL_REN:   return {31'h0, imem_if.imemREN};
         SEL_INSTR: return IF_instr;
         SEL_PC:    return IF_pc;
         SEL_NPC:   return IF_npc;
         SEL_VALID: return {31'h0, IF_valid};
         SEL_RS:    return {27'h0, IF_rs};
         SEL_RT:    return {27'h0, IF_rt};
         SEL_HALT:  return {31'h0, halted};
`ifdef FETCH_PERF_EN
         SEL_FCNT:  return fetch_count;
         SEL_SCNT:  return stall_count;
`endif
         default:   return 32'hx;
      endcase
   endfunction

   // dc=0: observed this cycle; dc=1: observed after the next rising edge.
   function automatic void exp_at(input int dc, input int sel, input logic [31:0] v);
      chk_t c;
      c.cyc = cyc + dc;
      c.sel = sel;
      c.exp = v;
      chk_q.push_back(c);
   endfunction

   function automatic void exp_load(input logic [31:0] pc, input logic [31:0] instr);
      load_t l;
      l.pc    = pc;
      l.instr = instr;
      load_q.push_back(l);
   endfunction

   // Monitor: tagged checks plus a load scoreboard popped whenever a new valid
   // instruction appears in the IF/ID latch.
   logic        last_valid = 1'b0;
   logic [31:0] last_pc = 32'h0;
   always @(negedge CLK) begin
      chk_t        c;
      load_t       l;
      logic [31:0] act;
      while (chk_q.size() > 0 && chk_q[0].cyc <= cyc) begin
         c = chk_q.pop_front();
         checks++;
         act = get_sig(c.sel);
         if (c.cyc < cyc) begin
            errors++;
            $display("FAIL %s: check for cycle %0d missed (now %0d)", sel_name(c.sel), c.cyc, cyc);
         end else if (act !== c.exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", sel_name(c.sel), cyc, act, c.exp);
         end
      end
      if (IF_valid === 1'b1 && (!last_valid || IF_pc !== last_pc)) begin
         checks++;
         if (load_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_load @cycle %0d: got pc %h instr %h, expected none", cyc, IF_pc, IF_instr);
         end else begin
            l = load_q.pop_front();
            if (IF_pc !== l.pc || IF_instr !== l.instr || IF_npc !== l.pc + 32'd4) begin
               errors++;
               $display("FAIL load @cycle %0d: got pc %h instr %h npc %h, expected pc %h instr %h npc %h",
                        cyc, IF_pc, IF_instr, IF_npc, l.pc, l.instr, l.pc + 32'd4);
            end
         end
      end
      last_valid = IF_valid;
      last_pc    = IF_pc;
   end

   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   task automatic drive(input logic pc_en, input logic if_en, input logic flush,
                        input logic hit, input logic [31:0] word);
      PC_EN            = pc_en;
      IF_EN            = if_en;
      IF_FLUSH         = flush;
      imem_if.ihit     = hit;
      imem_if.imemload = word;
      PCSrc            = 1'b0;
      ID_JR            = 1'b0;
      cu_Jump          = 1'b0;
      pr_halt          = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the end, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      nRST = 1'b0;
      iREN = 1'b1;
      branch_target = 32'h0;
      jr_target     = 32'h0;
      jump_target   = 32'h0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

      // reset state
      step();
      exp_at(0, SEL_REN, 0);
      exp_at(0, SEL_ADDR, PC_INIT);
      exp_at(0, SEL_VALID, 0);
      exp_at(0, SEL_INSTR, NOP_WORD);
      exp_at(0, SEL_PC, 0);
      exp_at(0, SEL_NPC, 0);
      exp_at(0, SEL_HALT, 0);
`ifdef FETCH_PERF_EN
      exp_at(0, SEL_FCNT, 0);
      exp_at(0, SEL_SCNT, 0);
`endif
      step();
      nRST = 1'b1;
      exp_at(0, SEL_REN, 1);

      // three back-to-back fetches
      step();
      drive(1'b1, 1'b1, 1'b0, 1'b1, W0);
      exp_at(0, SEL_ADDR, 32'h0); exp_load(32'h0, W0); exp_at(1, SEL_VALID, 1);
      step();
      drive(1'b1, 1'b1, 1'b0, 1'b1, W1);
      exp_at(0, SEL_ADDR, 32'h4); exp_load(32'h4, W1); exp_at(1, SEL_VALID, 1);
      step();
      drive(1'b1, 1'b1, 1'b0, 1'b1, W2);
      exp_at(0, SEL_ADDR, 32'h8); exp_load(32'h8, W2); exp_at(1, SEL_VALID, 1);
      exp_at(1, SEL_RS, 9); exp_at(1, SEL_RT, 10); exp_at(1, SEL_NPC, 32'hC);

      // bubble advances PC to 0x10
      step();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      exp_at(0, SEL_ADDR, 32'hC); exp_at(1, SEL_VALID, 0); exp_at(1, SEL_INSTR, NOP_WORD);

      // hold buffer: capture at 0x10 while stalled, release next cycle
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b1, W3);
      exp_at(0, SEL_ADDR, 32'h10); exp_at(0, SEL_REN, 1);
      exp_at(1, SEL_REN, 0); exp_at(1, SEL_VALID, 0);
      step();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      exp_load(32'h10, W3); exp_at(1, SEL_NPC, 32'h14); exp_at(1, SEL_REN, 1);

      // all redirects + flush + ihit together
      step();
      drive(1'b1, 1'b1, 1'b1, 1'b1, W4);
      PCSrc = 1'b1; branch_target = 32'h40;
      ID_JR = 1'b1; jr_target = 32'h80;
      cu_Jump = 1'b1; jump_target = 32'hC0;
      exp_at(1, SEL_ADDR, 32'h40); exp_at(1, SEL_VALID, 0); exp_at(1, SEL_INSTR, NOP_WORD);

      // remaining priority levels
      step();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      ID_JR = 1'b1; cu_Jump = 1'b1;
      exp_at(1, SEL_ADDR, 32'h80);
      step();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      cu_Jump = 1'b1;
      exp_at(1, SEL_ADDR, 32'hC0);
      step();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      cu_Jump = 1'b1; jump_target = 32'hFFFF_FFFC;
      exp_at(1, SEL_ADDR, 32'hFFFF_FFFC);

      // PC wrap
      step();
      drive(1'b1, 1'b1, 1'b0, 1'b1, W5);
      exp_at(0, SEL_ADDR, 32'hFFFF_FFFC); exp_load(32'hFFFF_FFFC, W5);
      exp_at(1, SEL_NPC, 32'h0); exp_at(1, SEL_ADDR, 32'h0);

      // hold buffer discarded by a branch
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b1, W6);
      exp_at(1, SEL_REN, 0);
      step();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      PCSrc = 1'b1; branch_target = 32'h100;
      exp_at(1, SEL_REN, 1); exp_at(1, SEL_ADDR, 32'h100); exp_at(1, SEL_VALID, 1);
      step();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      exp_at(1, SEL_VALID, 0);

      // halt
      step();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      pr_halt = 1'b1;
      exp_at(0, SEL_ADDR, 32'h104); exp_at(1, SEL_HALT, 1); exp_at(1, SEL_REN, 0);
      step();
      drive(1'b1, 1'b1, 1'b0, 1'b1, W7);
      for (int i = 0; i < 10; i++) begin
         exp_at(0, SEL_ADDR, 32'h108);
         exp_at(0, SEL_REN, 0);
         exp_at(0, SEL_HALT, 1);
         exp_at(0, SEL_VALID, 0);
         step();
      end

      // async reset pulse clears halt
      nRST = 1'b0;
      iREN = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      exp_at(0, SEL_ADDR, PC_INIT); exp_at(0, SEL_HALT, 0); exp_at(0, SEL_REN, 0);
      step();
      nRST = 1'b1;
      exp_at(0, SEL_REN, 0);

      // four stall cycles then two valid loads
      step();
      iREN = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_at(0, SEL_REN, 1);
         step();
      end
      drive(1'b1, 1'b1, 1'b0, 1'b1, WA);
      exp_load(32'h0, WA);
      step();
      drive(1'b1, 1'b1, 1'b0, 1'b1, WB);
      exp_load(32'h4, WB);
`ifdef FETCH_PERF_EN
      exp_at(1, SEL_FCNT, 2);
      exp_at(1, SEL_SCNT, 4);
`endif
      step();
      iREN = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      step();
      step();

      checks++;
      if (chk_q.size() != 0 || load_q.size() != 0) begin
         errors++;
         $display("FAIL leftover: got %0d checks and %0d loads pending, expected 0 and 0",
                  chk_q.size(), load_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined datapath; sits directly upstream of the hazard unit and consumes its PC_EN / IF_EN / IF_FLUSH / iREN / pr_halt controls.
- Owns the PC register, next-PC selection, the instruction-memory request, a one-entry hold buffer, and the IF/ID pipeline latch feeding decode.
- Its latched IF_rs / IF_rt fields feed the hazard unit's load-use check.

Parameters:
- PC_INIT, 32'h0000_0000, PC reset value.
- NOP_WORD, 32'h0000_0000, instruction word inserted on flush or bubble.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- PC_EN  in  1  PC update enable (hazard unit).
- IF_EN  in  1  IF/ID latch enable (hazard unit).
- IF_FLUSH  in  1  IF/ID latch flush (hazard unit).
- iREN  in  1  registered fetch enable (hazard unit).
- pr_halt  in  1  halt seen in decode (hazard unit).
- PCSrc  in  1  taken branch resolved in EX.
- branch_target  in  32  branch destination.
- ID_JR  in  1  JR resolved in EX.
- jr_target  in  32  rs value for JR.
- cu_Jump  in  1  J/JAL in decode.
- jump_target  in  32  decoded jump destination.
- ihit  in  1  instruction memory returned imemload this cycle.
- imemload  in  32  instruction word.
- imemREN  out  1  instruction read request.
- imemaddr  out  32  fetch address (= PC).
- IF_instr  out  32  latched instruction.
- IF_pc  out  32  latched PC of IF_instr.
- IF_npc  out  32  latched PC+4.
- IF_valid  out  1  latch holds a real instruction.
- IF_rs  out  5  IF_instr[25:21].
- IF_rt  out  5  IF_instr[20:16].
- halted  out  1  fetch permanently stopped.

Behaviour:
- Reset (async, nRST low): PC=PC_INIT; IF_instr=NOP_WORD; IF_pc=0; IF_npc=0; IF_valid=0; hold buffer empty; state=RUN; halted=0; imemREN=0 while reset asserted.
- Next PC priority: PCSrc→branch_target > ID_JR→jr_target > cu_Jump→jump_target > PC+4. Addition is mod 2^32; PC 32'hFFFF_FFFC wraps to 0.
- PC register: loads next PC on a rising edge when PC_EN=1 and state≠HALTED; otherwise holds.
- imemaddr = PC, combinational.
- imemREN = iREN && state==RUN.
- States:
  - RUN: normal fetch.
  - HOLD: ihit arrived while IF_EN=0 and IF_FLUSH=0. Capture imemload, PC and PC+4 into the hold buffer; imemREN=0.
  - HALTED: sticky until reset.
- Transitions:
  - RUN→HOLD on ihit && !IF_EN && !IF_FLUSH.
  - HOLD→RUN when IF_EN=1 (buffer moves to latch), or on IF_FLUSH / PCSrc / ID_JR (buffer discarded).
  - Any→HALTED on pr_halt=1; takes effect next edge.
- IF/ID latch, evaluated each edge:
  - IF_FLUSH=1 (wins over everything): IF_instr=NOP_WORD, IF_valid=0.
  - Else IF_EN=1 and state=HOLD: load from the hold buffer, IF_valid=1.
  - Else IF_EN=1 and ihit: load imemload / PC / PC+4, IF_valid=1.
  - Else IF_EN=1: bubble, IF_instr=NOP_WORD, IF_valid=0.
  - Else (IF_EN=0): hold contents.
- Simultaneous redirect and ihit: the latch follows the IF_FLUSH rule; the PC takes the redirect target; the fetched word is dropped.
- HALTED: PC frozen, imemREN=0, halted=1, latch accepts only IF_FLUSH.
- IF_rs / IF_rt are combinational slices of IF_instr.

Optional Feature:
- FETCH_PERF_EN defined: adds outputs fetch_count[31:0] and stall_count[31:0], both reset to 0.
  - fetch_count increments on every latch load with IF_valid=1.
  - stall_count increments on every cycle in RUN with imemREN=1 and ihit=0.
  - Both saturate at 32'hFFFF_FFFF and freeze in HALTED.
- Undefined: neither port nor counter exists; behaviour otherwise identical.

Test Plan:
- Reset with PC_INIT=0, then 3 consecutive ihit with PC_EN=IF_EN=1 → imemaddr 0,4,8; IF_pc 0,4,8; IF_valid=1 each cycle.
- ihit at PC=0x10 with IF_EN=0 and PC_EN=0, then IF_EN=1 next cycle with ihit=0 → IF_instr = word captured at 0x10, IF_pc=0x10, imemREN=0 during HOLD.
- PCSrc=1, branch_target=0x40, ID_JR=1, cu_Jump=1, IF_FLUSH=1, ihit=1 same cycle → PC=0x40, IF_valid=0, IF_instr=NOP_WORD.
- PC=0xFFFF_FFFC, PC_EN=1, no redirect → PC=0x0.
- pr_halt=1 for one cycle → halted=1, imemREN=0 and PC frozen for the next 10 cycles despite PC_EN=1. nRST pulse → PC=PC_INIT, halted=0.
- FETCH_PERF_EN defined: 4 ihit=0 cycles in RUN, then 2 valid loads → stall_count=4, fetch_count=2.
